node_link_queue: RTL

- Node-side stage directly upstream/downstream of the router core.
- TX path: buffers 29-bit packets written by the attached node and offers them one at a time to the core on Packet_From_Node / Packet_From_Node_Valid; retires each on Core_Load_Ack.
- RX path: captures 24-bit packets delivered by the core on Packet_To_Node / Packet_To_Node_Valid into a queue the node drains at its own pace.

---
 rtl/node_link_queue.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/node_link_queue.sv
// node_link_queue: node-side TX/RX buffering in front of the router core.
// TX: circular queue feeding a registered offer/ack handshake (IDLE/OFFER/RELEASE).
// RX: circular queue with first-word-fall-through read and sticky overflow.
// Optional: define NODE_LINK_QUEUE_STATS_EN to add tx_sent_cnt / rx_drop_cnt.
module node_link_queue #(
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic                      Clk_R,
  input  logic                      Rst,
  input  logic                      node_wr_en,
  input  logic [28:0]               node_wr_data,
  output logic                      node_tx_full,
  output logic [$clog2(TX_DEPTH):0] node_tx_count,
  output logic [28:0]               Packet_From_Node,
  output logic                      Packet_From_Node_Valid,
  input  logic                      Core_Load_Ack,
  input  logic [23:0]               Packet_To_Node,
  input  logic                      Packet_To_Node_Valid,
  input  logic                      node_rd_en,
  output logic [23:0]               node_rd_data,
  output logic                      node_rx_empty,
  output logic                      rx_overflow
`ifdef NODE_LINK_QUEUE_STATS_EN
  ,
  output logic [15:0]               tx_sent_cnt,
  output logic [15:0]               rx_drop_cnt
`endif
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW = TX_AW + 1;
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW = RX_AW + 1;
  localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);
  localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_OFFER, TX_RELEASE} tx_state_e;

  tx_state_e        tx_state_q;
  logic [28:0]      tx_mem_q [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
  logic [TX_CW-1:0] tx_count_q, tx_count_d;
  logic             tx_full_q;
  logic [28:0]      tx_pkt_q;
  logic             tx_valid_q;
  logic             tx_push, tx_pop;

  logic [23:0]      rx_mem_q [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
  logic [RX_CW-1:0] rx_count_q, rx_count_d;
  logic             rx_empty_q;
  logic             rx_overflow_q;
  logic             rx_full, rx_push, rx_pop, rx_drop;

  // Queue handshakes and exact next occupancy for both paths
  always_comb begin
    tx_push    = node_wr_en && !tx_full_q;
    tx_pop     = (tx_state_q == TX_OFFER) && Core_Load_Ack;
    tx_count_d = tx_count_q + TX_CW'(tx_push) - TX_CW'(tx_pop);
    rx_full    = (rx_count_q == RX_FULL_CNT);
    rx_pop     = node_rd_en && !rx_empty_q;
    rx_push    = Packet_To_Node_Valid && (!rx_full || rx_pop);
    rx_drop    = Packet_To_Node_Valid && rx_full && !rx_pop;
    rx_count_d = rx_count_q + RX_CW'(rx_push) - RX_CW'(rx_pop);
  end

  // TX storage write (contents are don't-care until counted)
  always_ff @(posedge Clk_R) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= node_wr_data;
  end

  // TX pointers, occupancy and offer FSM; the offered packet is frozen while in OFFER
  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      tx_state_q  <= TX_IDLE;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      tx_full_q   <= 1'b0;
      tx_pkt_q    <= '0;
      tx_valid_q  <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + TX_AW'(1);
      tx_count_q <= tx_count_d;
      tx_full_q  <= (tx_count_d == TX_FULL_CNT);
      case (tx_state_q)
        TX_IDLE: begin
          // A push into an empty queue is offered straight from the write port
          if (tx_count_q != '0) begin
            tx_pkt_q   <= tx_mem_q[tx_rd_ptr_q];
            tx_valid_q <= 1'b1;
            tx_state_q <= TX_OFFER;
          end else if (tx_push) begin
            tx_pkt_q   <= node_wr_data;
            tx_valid_q <= 1'b1;
            tx_state_q <= TX_OFFER;
          end
        end
        TX_OFFER: begin
          if (Core_Load_Ack) begin
            tx_valid_q <= 1'b0;
            tx_state_q <= TX_RELEASE;
          end
        end
        TX_RELEASE: begin
          // Count already reflects the pop, so the read pointer names the new head
          if (tx_count_q != '0) begin
            tx_pkt_q   <= tx_mem_q[tx_rd_ptr_q];
            tx_valid_q <= 1'b1;
            tx_state_q <= TX_OFFER;
          end else begin
            tx_state_q <= TX_IDLE;
          end
        end
        default: begin
          tx_valid_q <= 1'b0;
          tx_state_q <= TX_IDLE;
        end
      endcase
    end
  end

  // RX storage write
  always_ff @(posedge Clk_R) begin
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= Packet_To_Node;
  end

  // RX pointers, occupancy, empty flag and sticky overflow
  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      rx_wr_ptr_q   <= '0;
      rx_rd_ptr_q   <= '0;
      rx_count_q    <= '0;
      rx_empty_q    <= 1'b1;
      rx_overflow_q <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + RX_AW'(1);
      rx_count_q <= rx_count_d;
      rx_empty_q <= (rx_count_d == '0);
      if (rx_drop) rx_overflow_q <= 1'b1;
    end
  end

  assign node_tx_full           = tx_full_q;
  assign node_tx_count          = tx_count_q;
  assign Packet_From_Node       = tx_pkt_q;
  assign Packet_From_Node_Valid = tx_valid_q;
  assign node_rx_empty          = rx_empty_q;
  assign rx_overflow            = rx_overflow_q;
  // Head falls through from storage; forced to zero while empty so reset reads 0
  assign node_rd_data           = rx_empty_q ? 24'h0 : rx_mem_q[rx_rd_ptr_q];

`ifdef NODE_LINK_QUEUE_STATS_EN
  logic [15:0] tx_sent_q, rx_drop_q;

  // Saturating delivery and drop counters
  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      tx_sent_q <= '0;
      rx_drop_q <= '0;
    end else begin
      if (tx_pop && (tx_sent_q != 16'hFFFF))  tx_sent_q <= tx_sent_q + 16'd1;
      if (rx_drop && (rx_drop_q != 16'hFFFF)) rx_drop_q <= rx_drop_q + 16'd1;
    end
  end

  assign tx_sent_cnt = tx_sent_q;
  assign rx_drop_cnt = rx_drop_q;
`endif

endmodule
